// File: rtl/adc_tx_pkg.sv
// Shared types and constants for the AD9284 DDR pattern transmitter.
package adc_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRAIN = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam logic [2:0] MODE_RAMP  = 3'd0;
  localparam logic [2:0] MODE_PN9   = 3'd1;
  localparam logic [2:0] MODE_CHECK = 3'd2;
  localparam logic [2:0] MODE_FIXED = 3'd3;

  localparam logic [7:0] TRAIN_RISE = 8'hAA;
  localparam logic [7:0] TRAIN_FALL = 8'h55;

  localparam logic [8:0] PN9_SEED = 9'h1FF;

  // One step of x^9+x^5+1, shifting toward the MSB
  function automatic logic [8:0] pn9_step(input logic [8:0] v);
    return {v[7:0], v[8] ^ v[4]};
  endfunction

endpackage

// File: rtl/adc_tx_pn9.sv
// Two-step-per-cycle PN9 generator; outputs show the next pair so the
// parent can register them on the same edge the LFSR advances.
module adc_tx_pn9
  import adc_tx_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       advance,
  output logic [7:0] rise,
  output logic [7:0] fall,
  output logic       wrap
);

  logic [8:0] s;
  logic [8:0] base;
  logic [8:0] s1;
  logic [8:0] s2;

  always_comb begin
    base = load ? PN9_SEED : s;
    s1   = pn9_step(base);
    s2   = pn9_step(s1);
    rise = s1[7:0];
    fall = s2[7:0];
    wrap = (s2 == PN9_SEED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s <= '0;
    end else if (load || advance) begin
      s <= s2;
    end
  end

endmodule

// File: rtl/adc_ddr_pattern_tx.sv
// DDR test-pattern transmitter with training preamble for AD9284 capture.
// Define ADC_TX_PN9_EN to build the PN9 generator for mode 1.
module adc_ddr_pattern_tx
  import adc_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int TRAIN_LEN  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [2:0]            mode,
  input  logic [DATA_WIDTH-1:0] fixed_value,
  output logic [DATA_WIDTH-1:0] tx_data_rise,
  output logic [DATA_WIDTH-1:0] tx_data_fall,
  output logic                  tx_dco_rise,
  output logic                  tx_dco_fall,
  output logic                  tx_valid,
  output logic                  tx_train,
  output logic                  pattern_wrap
);

  state_t                state;
  logic [2:0]            mode_q;
  logic [7:0]            cnt;
  logic [DATA_WIDTH-1:0] n;

  logic                  last;
  logic                  run_entry;
  logic                  run_stay;
  logic                  to_train;
  logic                  to_run;
  logic [DATA_WIDTH-1:0] ramp_base;
  logic [DATA_WIDTH-1:0] pat_rise;
  logic [DATA_WIDTH-1:0] pat_fall;
  logic                  pat_wrap;

`ifdef ADC_TX_PN9_EN
  logic [7:0] pn_rise;
  logic [7:0] pn_fall;
  logic       pn_wrap;

  adc_tx_pn9 u_pn9 (
    .clk     (clk),
    .rst     (rst),
    .load    (run_entry),
    .advance (run_stay),
    .rise    (pn_rise),
    .fall    (pn_fall),
    .wrap    (pn_wrap)
  );
`endif

  always_comb begin
    last      = (cnt == 8'(TRAIN_LEN - 1));
    run_entry = enable && (state == TRAIN) && last;
    run_stay  = enable && (state == RUN) && (mode == mode_q);
    to_run    = run_entry || run_stay;
    to_train  = enable && ((state == IDLE) ||
                           (state == TRAIN && !last) ||
                           (state == RUN && mode != mode_q));
    ramp_base = run_entry ? '0 : n;
    pat_rise  = '0;
    pat_fall  = '0;
    pat_wrap  = 1'b0;
    case (mode_q)
      MODE_RAMP: begin
        pat_rise = ramp_base;
        pat_fall = ramp_base + DATA_WIDTH'(1);
        pat_wrap = (ramp_base == DATA_WIDTH'(8'hFE));
      end
`ifdef ADC_TX_PN9_EN
      MODE_PN9: begin
        pat_rise = pn_rise;
        pat_fall = pn_fall;
        pat_wrap = pn_wrap;
      end
`endif
      MODE_CHECK: begin
        pat_rise = TRAIN_RISE;
        pat_fall = TRAIN_FALL;
        pat_wrap = 1'b1;
      end
      MODE_FIXED: begin
        pat_rise = fixed_value;
        pat_fall = fixed_value;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      mode_q       <= '0;
      cnt          <= '0;
      n            <= '0;
      tx_data_rise <= '0;
      tx_data_fall <= '0;
      tx_dco_rise  <= 1'b0;
      tx_dco_fall  <= 1'b0;
      tx_valid     <= 1'b0;
      tx_train     <= 1'b0;
      pattern_wrap <= 1'b0;
    end else begin
      unique case (1'b1)
        to_train: begin
          state <= TRAIN;
          // a fresh entry restarts the count and captures the new mode
          if (state == TRAIN) begin
            cnt <= cnt + 8'd1;
          end else begin
            cnt    <= '0;
            mode_q <= mode;
          end
          tx_data_rise <= TRAIN_RISE;
          tx_data_fall <= TRAIN_FALL;
          tx_dco_rise  <= 1'b1;
          tx_dco_fall  <= 1'b0;
          tx_valid     <= 1'b1;
          tx_train     <= 1'b1;
          pattern_wrap <= 1'b0;
        end
        to_run: begin
          state        <= RUN;
          n            <= ramp_base + DATA_WIDTH'(2);
          tx_data_rise <= pat_rise;
          tx_data_fall <= pat_fall;
          tx_dco_rise  <= 1'b1;
          tx_dco_fall  <= 1'b0;
          tx_valid     <= 1'b1;
          tx_train     <= 1'b0;
          pattern_wrap <= pat_wrap;
        end
        default: begin
          state        <= IDLE;
          tx_data_rise <= '0;
          tx_data_fall <= '0;
          tx_dco_rise  <= 1'b0;
          tx_dco_fall  <= 1'b0;
          tx_valid     <= 1'b0;
          tx_train     <= 1'b0;
          pattern_wrap <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_ddr_pattern_tx.sv
// Randomized and directed bench for adc_ddr_pattern_tx against a
// sequence-index reference model.
module tb_adc_ddr_pattern_tx;

  localparam int TL = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [2:0] mode = 3'd0;
  logic [7:0] fixed_value = 8'd0;
  logic [7:0] tx_data_rise;
  logic [7:0] tx_data_fall;
  logic       tx_dco_rise;
  logic       tx_dco_fall;
  logic       tx_valid;
  logic       tx_train;
  logic       pattern_wrap;

  adc_ddr_pattern_tx #(.DATA_WIDTH(8), .TRAIN_LEN(TL)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .mode         (mode),
    .fixed_value  (fixed_value),
    .tx_data_rise (tx_data_rise),
    .tx_data_fall (tx_data_fall),
    .tx_dco_rise  (tx_dco_rise),
    .tx_dco_fall  (tx_dco_fall),
    .tx_valid     (tx_valid),
    .tx_train     (tx_train),
    .pattern_wrap (pattern_wrap)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic check(input string tag, input logic [20:0] obs,
                       input logic [20:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // model: phase 0 idle, 1 training (tc words sent), 2 run (ri = run index)
  int         ph = 0;
  int         tc = 0;
  int         ri = 0;
  logic [2:0] mq = 3'd0;
  logic [20:0] exp_v = '0;
  logic [8:0] pn_st [511];

  initial begin
    logic [8:0] v;
    pn_st[0] = 9'h1FF;
    for (int k = 1; k < 511; k++) begin
      v = pn_st[k-1];
      pn_st[k] = {v[7:0], v[8] ^ v[4]};
    end
  end

  task automatic model_step();
    logic [7:0] r;
    logic [7:0] f;
    logic       w;
    int         a;
    int         b;
    if (rst) begin
      ph = 0;
    end else begin
      case (ph)
        0: if (enable) begin ph = 1; tc = 1; mq = mode; end
        1: begin
          if (!enable) ph = 0;
          else if (tc == TL) begin ph = 2; ri = 0; end
          else tc++;
        end
        default: begin
          if (!enable) ph = 0;
          else if (mode != mq) begin ph = 1; tc = 1; mq = mode; end
          else ri++;
        end
      endcase
    end
    r = 8'h00; f = 8'h00; w = 1'b0;
    if (ph == 0) begin
      exp_v = '0;
    end else if (ph == 1) begin
      exp_v = {8'hAA, 8'h55, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    end else begin
      case (mq)
        3'd0: begin
          r = 8'((2 * ri) % 256);
          f = 8'((2 * ri + 1) % 256);
          w = (r == 8'hFE);
        end
`ifdef ADC_TX_PN9_EN
        3'd1: begin
          a = (2 * ri + 1) % 511;
          b = (2 * ri + 2) % 511;
          r = pn_st[a][7:0];
          f = pn_st[b][7:0];
          w = (b == 0);
        end
`endif
        3'd2: begin r = 8'hAA; f = 8'h55; w = 1'b1; end
        3'd3: begin r = fixed_value; f = fixed_value; end
        default: ;
      endcase
      exp_v = {r, f, 1'b1, 1'b0, 1'b1, 1'b0, w};
    end
  endtask

  task automatic cyc(input logic r, input logic e, input logic [2:0] m,
                     input logic [7:0] fv, input string tag);
    rst = r; enable = e; mode = m; fixed_value = fv;
    @(posedge clk);
    model_step();
    #1;
    check(tag, {tx_data_rise, tx_data_fall, tx_dco_rise, tx_dco_fall,
                tx_valid, tx_train, pattern_wrap}, exp_v);
  endtask

  initial begin
    logic       e;
    logic [2:0] m;
    int         guard;
    repeat (3) cyc(1'b1, 1'b0, 3'd0, 8'h00, "reset");
    cyc(1'b0, 1'b0, 3'd0, 8'h00, "idle");
    repeat (200) cyc(1'b0, 1'b1, 3'd0, 8'h00, "ramp");
    // rewind into a fresh ramp and stop at rise=0x40 to reset mid-run
    cyc(1'b0, 1'b0, 3'd0, 8'h00, "ramp_off");
    guard = 0;
    while (!(ph == 2 && exp_v[20:13] == 8'h40) && guard < 100) begin
      cyc(1'b0, 1'b1, 3'd0, 8'h00, "ramp_to40");
      guard++;
    end
    check("reach_0x40", 21'(guard < 100), 21'd1);
    cyc(1'b1, 1'b1, 3'd0, 8'h00, "rst_mid_run");
    repeat (TL + 4) cyc(1'b0, 1'b1, 3'd0, 8'h00, "ramp_restart");
    // PN9 (reserved output when the generator is not built)
    repeat (1100) cyc(1'b0, 1'b1, 3'd1, 8'h00, "pn9");
    repeat (TL + 4) cyc(1'b0, 1'b1, 3'd3, 8'h5A, "fixed_5a");
    repeat (4) cyc(1'b0, 1'b1, 3'd3, 8'hC3, "fixed_c3");
    repeat (TL + 4) cyc(1'b0, 1'b1, 3'd0, 8'h00, "ramp2");
    repeat (TL + 6) cyc(1'b0, 1'b1, 3'd2, 8'h00, "check");
    // mode change inside training, applied after RUN entry
    repeat (5) cyc(1'b0, 1'b1, 3'd0, 8'h00, "train_chg_a");
    repeat (TL + 6) cyc(1'b0, 1'b1, 3'd7, 8'h00, "train_chg_b");
    cyc(1'b0, 1'b0, 3'd3, 8'h00, "drop_and_chg");
    cyc(1'b0, 1'b0, 3'd3, 8'h00, "idle2");
    e = 1'b1;
    m = 3'd0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 49) == 0) e = ~e;
      if ($urandom_range(0, 79) == 0) m = 3'($urandom_range(0, 7));
      cyc(1'($urandom_range(0, 399) == 0), e, m, 8'($urandom), "rand");
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
